// File: rtl/e_mdu.sv
// e_mdu: multi-cycle MIPS mult/div unit owning HI/LO; in: Start, MDU_Op, SrcA, SrcB, D_Uses_MDU; out: Busy, Stall, HI, LO, MDU_Out
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDU_Op,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        D_Uses_MDU,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_Out
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
  logic dz_q, dz_d;
  logic is_mul, is_div, go, sdiv;
  logic [63:0] ea, eb, prod;
  logic [31:0] a_abs, b_abs, q_abs, r_abs, quo, rem;
  assign is_mul = MDU_Op == 4'd1 || MDU_Op == 4'd2;
  assign is_div = MDU_Op == 4'd3 || MDU_Op == 4'd4;
  assign go = Start && (is_mul || is_div);
  assign sdiv = MDU_Op == 4'd3;
  assign ea = {{32{MDU_Op == 4'd1 && SrcA[31]}}, SrcA};
  assign eb = {{32{MDU_Op == 4'd1 && SrcB[31]}}, SrcB};
  assign prod = ea * eb;
  assign a_abs = sdiv && SrcA[31] ? -SrcA : SrcA;
  assign b_abs = sdiv && SrcB[31] ? -SrcB : SrcB;
  assign q_abs = b_abs == '0 ? '0 : a_abs / b_abs;
  assign r_abs = b_abs == '0 ? '0 : a_abs % b_abs;
  assign quo = sdiv && (SrcA[31] ^ SrcB[31]) ? -q_abs : q_abs;
  assign rem = sdiv && SrcA[31] ? -r_abs : r_abs;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    dz_d = dz_q;
    if (state_q == IDLE) begin
      if (go) begin
        state_d = BUSY;
        cnt_d = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        tmp_hi_d = is_mul ? prod[63:32] : rem;
        tmp_lo_d = is_mul ? prod[31:0] : quo;
        dz_d = is_div && SrcB == '0;
      end
      hi_d = Start && MDU_Op == 4'd7 ? SrcA : hi_q;
      lo_d = Start && MDU_Op == 4'd8 ? SrcA : lo_q;
    end else begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        hi_d = dz_q ? hi_q : tmp_hi_q;
        lo_d = dz_q ? lo_q : tmp_lo_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      dz_q <= dz_d;
    end
  end
  assign Busy = state_q == BUSY;
  assign Stall = D_Uses_MDU && (Busy || go);
  assign HI = hi_q;
  assign LO = lo_q;
  assign MDU_Out = MDU_Op == 4'd5 ? hi_q : lo_q;
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed plus randomized checks of e_mdu against a plain-arithmetic HI/LO model
module tb_e_mdu;
  logic clk = 1'b0, reset, Start, D_Uses_MDU, Busy, Stall;
  logic [3:0] MDU_Op;
  logic [31:0] SrcA, SrcB, HI, LO, MDU_Out;
  logic [31:0] model_hi, model_lo;
  int checks = 0, errors = 0;
  e_mdu dut (
    .clk(clk), .reset(reset), .Start(Start), .MDU_Op(MDU_Op), .SrcA(SrcA), .SrcB(SrcB),
    .D_Uses_MDU(D_Uses_MDU), .Busy(Busy), .Stall(Stall), .HI(HI), .LO(LO), .MDU_Out(MDU_Out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] eh, output logic [31:0] el, output bit wr);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    eh = model_hi;
    el = model_lo;
    wr = 1'b1;
    case (op)
      4'd1: begin sq = sa * sb; eh = sq[63:32]; el = sq[31:0]; end
      4'd2: begin uq = ua * ub; eh = uq[63:32]; el = uq[31:0]; end
      4'd3: if (b == 0) wr = 1'b0; else begin sq = sa / sb; sr = sa % sb; el = sq[31:0]; eh = sr[31:0]; end
      4'd4: if (b == 0) wr = 1'b0; else begin uq = ua / ub; ur = ua % ub; el = uq[31:0]; eh = ur[31:0]; end
      4'd7: eh = a;
      4'd8: el = a;
      default: ;
    endcase
  endtask
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic du, input bit mid);
    logic [31:0] eh, el;
    bit wr, md;
    int n;
    md = op inside {[4'd1:4'd4]};
    n = op <= 4'd2 ? 5 : 10;
    ref_op(op, a, b, eh, el, wr);
    Start = 1'b1;
    MDU_Op = op;
    SrcA = a;
    SrcB = b;
    D_Uses_MDU = du;
    #1;
    chk("stall_start", 32'(Stall), 32'(du && md));
    chk("mdu_out", MDU_Out, op == 4'd5 ? model_hi : model_lo);
    @(negedge clk);
    Start = 1'b0;
    if (md) begin
      for (int k = 1; k <= n; k++) begin
        chk("busy_hold", 32'(Busy), 32'd1);
        chk("stall_busy", 32'(Stall), 32'(du));
        chk("hi_hold", HI, model_hi);
        chk("lo_hold", LO, model_lo);
        if (mid && k == 2) begin
          Start = 1'b1;
          MDU_Op = 4'($urandom_range(1, 8));
          SrcA = $urandom;
          SrcB = $urandom;
        end else Start = 1'b0;
        @(negedge clk);
      end
      Start = 1'b0;
      #1;
    end
    if (wr) begin
      model_hi = eh;
      model_lo = el;
    end
    chk("busy_done", 32'(Busy), 32'd0);
    chk("stall_done", 32'(Stall), 32'd0);
    chk("hi", HI, model_hi);
    chk("lo", LO, model_lo);
  endtask
  initial begin
    logic [3:0] op;
    logic [31:0] a, b;
    reset = 1'b1;
    Start = 1'b1;
    MDU_Op = 4'd1;
    SrcA = 32'd3;
    SrcB = 32'd4;
    D_Uses_MDU = 1'b0;
    model_hi = '0;
    model_lo = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_out", MDU_Out, 32'd0);
    reset = 1'b0;
    Start = 1'b0;
    #1 chk("rst_stall", 32'(Stall), 32'd0);
    @(negedge clk);
    do_op(4'd1, 32'hFFFFFFFD, 32'd5, 1'b1, 1'b1);
    chk("mult_hi_c", HI, 32'hFFFFFFFF);
    chk("mult_lo_c", LO, 32'hFFFFFFF1);
    do_op(4'd2, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0);
    chk("multu_hi_c", HI, 32'h00000004);
    chk("multu_lo_c", LO, 32'hFFFFFFF1);
    do_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
    chk("div_lo_c", LO, 32'hFFFFFFFD);
    chk("div_hi_c", HI, 32'hFFFFFFFF);
    do_op(4'd4, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
    chk("divu_lo_c", LO, 32'h7FFFFFFC);
    chk("divu_hi_c", HI, 32'h00000001);
    do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    chk("div_ovf_lo", LO, 32'h80000000);
    chk("div_ovf_hi", HI, 32'h00000000);
    do_op(4'd7, 32'h12345678, 32'd0, 1'b1, 1'b0);
    do_op(4'd3, 32'd7, 32'd0, 1'b1, 1'b0);
    chk("dz_hi_c", HI, 32'h12345678);
    do_op(4'd5, 32'd0, 32'd0, 1'b1, 1'b0);
    do_op(4'd8, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0);
    do_op(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 8));
      a = $urandom;
      b = $urandom_range(0, 3) == 0 ? 32'd0 : ($urandom_range(0, 1) == 0 ? $urandom : 32'($urandom_range(1, 9)));
      do_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    Start = 1'b1;
    MDU_Op = 4'd3;
    SrcA = 32'd100;
    SrcB = 32'd3;
    D_Uses_MDU = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    for (int k = 1; k < 4; k++) begin
      chk("rdiv_busy", 32'(Busy), 32'd1);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rdiv_busy0", 32'(Busy), 32'd0);
    chk("rdiv_hi0", HI, 32'd0);
    chk("rdiv_lo0", LO, 32'd0);
    repeat (12) @(negedge clk);
    chk("rdiv_busy_late", 32'(Busy), 32'd0);
    chk("rdiv_hi_late", HI, 32'd0);
    chk("rdiv_lo_late", LO, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
